// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for an RV32I core.
// Registers the MEM-stage fields, selects the write-back data, extracts and
// extends load data, drives the register-file write port and counts retired
// instructions.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_word,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_imm,
  output logic        en,
  output logic [31:0] register_file_data,
  output logic [4:0]  rd,
  output logic        wb_valid,
  output logic [31:0] retired_count
);

  // Selects the addressed byte/halfword of an aligned word and extends it.
  // A halfword uses only off[1]; off[0] is ignored. Reserved funct3
  // encodings pass the whole word through.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic        valid_q,     valid_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  wb_sel_q,    wb_sel_d;
  logic [2:0]  funct3_q,    funct3_d;
  logic [4:0]  rd_q,        rd_d;
  logic [31:0] alu_q,       alu_d;
  logic [31:0] word_q,      word_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] imm_q,       imm_d;
  logic [31:0] retired_count_q, retired_count_d;

  // Next-state: flush loads a bubble, stall holds, otherwise capture MEM fields.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    word_d      = word_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      wb_sel_d    = 2'b00;
      funct3_d    = 3'b000;
      rd_d        = 5'd0;
      alu_d       = 32'd0;
      word_d      = 32'd0;
      pc_d        = 32'd0;
      imm_d       = 32'd0;
    end else if (stall) begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
    end else begin
      valid_d     = mem_valid;
      reg_write_d = mem_reg_write;
      wb_sel_d    = mem_wb_sel;
      funct3_d    = mem_funct3;
      rd_d        = mem_rd;
      alu_d       = mem_alu_result;
      word_d      = mem_load_word;
      pc_d        = mem_pc;
      imm_d       = mem_imm;
    end
  end

  // Retirement counter: the instruction in WB retires when it leaves
  // (not stalled); flush still lets it retire. Wraps naturally at 2^32.
  always_comb begin
    if (valid_q && !stall) begin
      retired_count_d = retired_count_q + 32'd1;
    end else begin
      retired_count_d = retired_count_q;
    end
  end

  // WB state registers with synchronous reset overriding flush and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      wb_sel_q        <= 2'b00;
      funct3_q        <= 3'b000;
      rd_q            <= 5'd0;
      alu_q           <= 32'd0;
      word_q          <= 32'd0;
      pc_q            <= 32'd0;
      imm_q           <= 32'd0;
      retired_count_q <= 32'd0;
    end else begin
      valid_q         <= valid_d;
      reg_write_q     <= reg_write_d;
      wb_sel_q        <= wb_sel_d;
      funct3_q        <= funct3_d;
      rd_q            <= rd_d;
      alu_q           <= alu_d;
      word_q          <= word_d;
      pc_q            <= pc_d;
      imm_q           <= imm_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Write-back data select and write enable from the registered fields.
  always_comb begin
    case (wb_sel_q)
      2'b00:   register_file_data = alu_q;
      2'b01:   register_file_data = load_extract(funct3_q, alu_q[1:0], word_q);
      2'b10:   register_file_data = pc_q + 32'd4;
      2'b11:   register_file_data = imm_q;
      default: register_file_data = alu_q;
    endcase
    en = valid_q && reg_write_q && (rd_q != 5'd0);
  end

  assign rd            = rd_q;
  assign wb_valid      = valid_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven vectors plus hand
// sequences for stall, flush, reset override and counter wrap. Expected
// values are queued when stimulus is driven and popped after the edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, mem_valid, mem_reg_write;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result, mem_load_word, mem_pc, mem_imm;
  logic        en, wb_valid;
  logic [31:0] register_file_data, retired_count;
  logic [4:0]  rd;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
    .mem_pc(mem_pc), .mem_imm(mem_imm),
    .en(en), .register_file_data(register_file_data), .rd(rd),
    .wb_valid(wb_valid), .retired_count(retired_count)
  );

  typedef struct {
    logic        rst, stall, flush, valid, rw;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, word, pc, imm;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_valid;
    logic        ctl_only;
    logic        skip_cnt;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        valid;
    logic [31:0] cnt;
    logic        ctl_only;
    logic        skip_cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_cnt    = 32'd0;
  localparam logic [31:0] W = 32'h80FF_7F01;

  function automatic vec_t mk(input logic r, s, f, va, rw, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [4:0] rdi,
                              input logic [31:0] alu, word, pc, imm,
                              input logic een, input logic [4:0] erd,
                              input logic [31:0] edata, input logic evalid);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.valid = va; v.rw = rw;
    v.sel = sel; v.f3 = f3; v.rd = rdi; v.alu = alu; v.word = word;
    v.pc = pc; v.imm = imm; v.e_en = een; v.e_rd = erd; v.e_data = edata;
    v.e_valid = evalid; v.ctl_only = 1'b0; v.skip_cnt = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; flush = v.flush; mem_valid = v.valid;
    mem_reg_write = v.rw; mem_wb_sel = v.sel; mem_funct3 = v.f3; mem_rd = v.rd;
    mem_alu_result = v.alu; mem_load_word = v.word; mem_pc = v.pc; mem_imm = v.imm;
    // count model: the instruction currently in WB retires on this edge
    if (v.rst) m_cnt = 32'd0;
    else if (m_valid && !v.stall) m_cnt = m_cnt + 32'd1;
    m_valid = v.e_valid;
    e.en = v.e_en; e.rd = v.e_rd; e.data = v.e_data; e.valid = v.e_valid;
    e.cnt = m_cnt; e.ctl_only = v.ctl_only; e.skip_cnt = v.skip_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({nm, ".en"}, 32'(en), 32'(e.en));
    chk({nm, ".wb_valid"}, 32'(wb_valid), 32'(e.valid));
    if (!e.ctl_only) begin
      chk({nm, ".rd"}, 32'(rd), 32'(e.rd));
      chk({nm, ".data"}, register_file_data, e.data);
    end
    if (!e.skip_cnt) chk({nm, ".count"}, retired_count, e.cnt);
  endtask

  vec_t tbl[16];
  vec_t v;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_reg_write = 1'b0;
    mem_wb_sel = 2'b00; mem_funct3 = 3'b000; mem_rd = 5'd0;
    mem_alu_result = 32'd0; mem_load_word = 32'd0; mem_pc = 32'd0; mem_imm = 32'd0;

    // reset for two cycles with a valid random instruction at the MEM inputs
    for (int i = 0; i < 2; i++) begin
      v = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'($urandom), 3'($urandom), 5'($urandom),
             $urandom, $urandom, $urandom, $urandom, 1'b0, 5'd0, 32'd0, 1'b0);
      apply(v, "reset");
    end

    //          rst   stall flush valid rw    sel    f3      rd     alu            word   pc             imm            en    rd     data           valid
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd5,  32'h12345678, 32'd0, 32'd0,         32'd0,         1'b1, 5'd5,  32'h12345678, 1'b1);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 5'd6,  32'h00001001, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'h0000007F, 1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 5'd6,  32'h00000002, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'hFFFFFFFF, 1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b100, 5'd6,  32'h00000003, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'h00000080, 1'b1);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b001, 5'd6,  32'h00000002, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'hFFFF80FF, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b101, 5'd6,  32'h00000000, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'h00007F01, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b010, 5'd6,  32'h00000000, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'h80FF7F01, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b001, 5'd6,  32'h00000001, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'h00007F01, 1'b1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b101, 5'd6,  32'h00000003, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'h000080FF, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b110, 5'd6,  32'h00000001, W,     32'd0,         32'd0,         1'b1, 5'd6,  32'h80FF7F01, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd0,  32'h0000AAAA, 32'd0, 32'd0,         32'd0,         1'b0, 5'd0,  32'h0000AAAA, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 3'b000, 5'd1,  32'd0,        32'd0, 32'hFFFFFFFC, 32'd0,         1'b1, 5'd1,  32'h00000000, 1'b1);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 3'b000, 5'd1,  32'd0,        32'd0, 32'h00000100, 32'd0,         1'b1, 5'd1,  32'h00000104, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 3'b000, 5'd7,  32'd0,        32'd0, 32'd0,         32'hABCDE000, 1'b1, 5'd7,  32'hABCDE000, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 5'd8,  32'h00000005, 32'd0, 32'd0,         32'd0,         1'b0, 5'd8,  32'h00000005, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd9,  32'h00000003, 32'd0, 32'd0,         32'd0,         1'b0, 5'd9,  32'h00000003, 1'b0);
    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // stall: capture A, hold it three cycles while MEM inputs change, then release
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd10, 32'h0000CAFE, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd10, 32'h0000CAFE, 1'b1), "stallA");
    for (int i = 0; i < 3; i++)
      apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 3'b000, 5'd11, 32'h1, 32'd0, 32'd0, 32'h00000BAD,
               1'b1, 5'd10, 32'h0000CAFE, 1'b1), "stall_hold");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 3'b000, 5'd11, 32'h1, 32'd0, 32'd0, 32'h00000BAD,
             1'b1, 5'd11, 32'h00000BAD, 1'b1), "stall_release");

    // flush: incoming instruction dropped, the one in WB still retires
    v = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000, 5'd12, 32'h77, 32'd0, 32'd0, 32'd0,
           1'b0, 5'd0, 32'd0, 1'b0);
    v.ctl_only = 1'b1;
    apply(v, "flush");

    // stall together with flush: a bubble is captured over a held valid instruction
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd13, 32'h55, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd13, 32'h00000055, 1'b1), "pre_sf");
    v = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000, 5'd14, 32'h66, 32'd0, 32'd0, 32'd0,
           1'b0, 5'd0, 32'd0, 1'b0);
    v.ctl_only = 1'b1;
    v.skip_cnt = 1'b1;
    apply(v, "stall_flush");

    // reset overrides stall and flush and discards the instruction in WB
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd15, 32'h99, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd15, 32'h00000099, 1'b1), "pre_rst");
    apply(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000, 5'd16, 32'h88, 32'd0, 32'd0, 32'd0,
             1'b0, 5'd0, 32'd0, 1'b0), "rst_override");

    // counter wrap: capture one, preload the counter to all-ones, let it retire
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'h11, 32'd0, 32'd0, 32'd0,
             1'b1, 5'd3, 32'h00000011, 1'b1), "wrap_cap");
    force dut.retired_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count_q;
    m_cnt = 32'hFFFF_FFFF;
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd4, 32'h22, 32'd0, 32'd0, 32'd0,
             1'b0, 5'd4, 32'h00000022, 1'b0), "wrap");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd4, 32'h22, 32'd0, 32'd0, 32'd0,
             1'b0, 5'd4, 32'h00000022, 1'b0), "bubble_nocount");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
